pie_decoder: RTL and testbench

PIE_DECODER -- requirements
Module: pie_decoder

---
 rtl/pie_pkg.sv | 17 +
 rtl/sync_edge_detect.sv | 28 ++
 rtl/pie_decoder.sv | 159 +++++++++++++++
 tb/tb_pie_decoder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pie_pkg.sv
// Shared state encoding and default sizing for the PIE downlink decoder.
package pie_pkg;

  localparam int unsigned PIE_CNT_W     = 9;
  localparam int unsigned PIE_DELIM_MIN = 8;
  localparam int unsigned PIE_TIMEOUT   = 511;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELIM,
    S_TARI,
    S_RTCAL,
    S_FIRST,
    S_DATA
  } pie_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for the asynchronous envelope input, followed by
// registered single-cycle rise/fall strobes on the synchronized level.
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic rise,
  output logic fall
);

  // [0] metastable capture, [1] synchronized level, [2] previous level
  logic [2:0] sync_q;

  // NOTE: every flop here uses <= so all stages shift on the same edge;
  // blocking assignments would collapse the chain into a single flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
      rise   <= sync_q[1] & ~sync_q[2];
      fall   <= ~sync_q[1] & sync_q[2];
    end
  end

endmodule

// File: rtl/pie_decoder.sv
// PIE downlink decoder: measures delimiter, Tari, RTcal and optional TRcal,
// then slices each rising-edge-to-rising-edge interval against RTcal/2.
module pie_decoder
  import pie_pkg::*;
#(
  parameter int unsigned CNT_W     = PIE_CNT_W,
  parameter int unsigned DELIM_MIN = PIE_DELIM_MIN,
  parameter int unsigned TIMEOUT   = PIE_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enabled,
  input  logic             demod_in,
  output logic             bit_data,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             is_query,
  output logic             frame_end,
  output logic             error,
  output logic [CNT_W-1:0] tari,
  output logic [CNT_W-1:0] rtcal,
  output logic [CNT_W-1:0] trcal
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] DELIM_C   = CNT_W'(DELIM_MIN);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             rise;
  logic             fall;
  pie_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] half_rtcal;
  logic             timeout;
  logic [CNT_W-1:0] tari_q, rtcal_q, trcal_q;
  logic             is_query_q, bit_data_q;
  logic             bit_valid_q, frame_start_q, frame_end_q, error_q;

  sync_edge_detect u_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (demod_in),
    .rise    (rise),
    .fall    (fall)
  );

  // elapsed counts the current clock, so an edge sees the full spacing
  assign elapsed    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout    = (elapsed >= TIMEOUT_C);
  assign half_rtcal = rtcal_q >> 1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tari_q        <= '0;
      rtcal_q       <= '0;
      trcal_q       <= '0;
      is_query_q    <= 1'b0;
      bit_data_q    <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      error_q       <= 1'b0;
      if (enabled) begin
        cnt_q <= elapsed;
        // Timeout outranks any edge in the same cycle; that edge is dropped.
        case (state_q)
          S_IDLE: begin
            if (fall) begin
              cnt_q   <= '0;
              state_q <= S_DELIM;
            end
          end
          S_DELIM: begin
            if (timeout) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else if (rise) begin
              cnt_q   <= '0;
              state_q <= (elapsed >= DELIM_C) ? S_TARI : S_IDLE;
            end
          end
          S_TARI: begin
            if (timeout) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else if (rise) begin
              tari_q  <= elapsed;
              cnt_q   <= '0;
              state_q <= S_RTCAL;
            end
          end
          S_RTCAL: begin
            if (timeout) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else if (rise) begin
              rtcal_q <= elapsed;
              cnt_q   <= '0;
              if (elapsed <= tari_q) begin
                error_q <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_FIRST;
              end
            end
          end
          S_FIRST: begin
            if (timeout) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else if (rise) begin
              cnt_q         <= '0;
              frame_start_q <= 1'b1;
              state_q       <= S_DATA;
              if (elapsed > rtcal_q) begin
                trcal_q    <= elapsed;
                is_query_q <= 1'b1;
              end else begin
                is_query_q  <= 1'b0;
                bit_data_q  <= (elapsed >= half_rtcal);
                bit_valid_q <= 1'b1;
              end
            end
          end
          S_DATA: begin
            if (timeout) begin
              frame_end_q <= 1'b1;
              state_q     <= S_IDLE;
            end else if (rise) begin
              cnt_q       <= '0;
              bit_data_q  <= (elapsed >= half_rtcal);
              bit_valid_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bit_data    = bit_data_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign is_query    = is_query_q;
  assign frame_end   = frame_end_q;
  assign error       = error_q;
  assign tari        = tari_q;
  assign rtcal       = rtcal_q;
  assign trcal       = trcal_q;

endmodule

// File: tb/tb_pie_decoder.sv
// Self-checking bench for pie_decoder: directed and random PIE frames scored
// against an interval-level model of the frame format.
module tb_pie_decoder;

  localparam int CNT_W     = 9;
  localparam int DELIM_MIN = 8;
  localparam int TIMEOUT   = 511;
  localparam int PW        = 3;  // low pulse width inside each symbol
  localparam int LAT       = 4;  // drive cycle to registered pulse

  logic             clock = 1'b0;
  logic             reset, enabled, demod_in;
  logic             bit_data, bit_valid, frame_start, is_query, frame_end, error;
  logic [CNT_W-1:0] tari, rtcal, trcal;

  pie_decoder #(.CNT_W(CNT_W), .DELIM_MIN(DELIM_MIN), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .enabled(enabled), .demod_in(demod_in),
    .bit_data(bit_data), .bit_valid(bit_valid), .frame_start(frame_start),
    .is_query(is_query), .frame_end(frame_end), .error(error),
    .tari(tari), .rtcal(rtcal), .trcal(trcal)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  logic en_last = 1'b1;
  logic bit_q[$];
  int   bit_cyc[$];
  int   fs_cnt = 0, fe_cnt = 0, err_cnt = 0, dis_pulse = 0;
  int   fs_cyc = 0, fe_cyc = 0, err_cyc = 0;
  int   rise_cyc[$];

  // model state
  logic e_bits[$];
  bit   e_fs, e_fe, e_err;
  int   m_tari = 0, m_rtcal = 0, m_trcal = 0;
  bit   m_isq = 0;

  always @(posedge clock) begin
    cyc     <= cyc + 1;
    en_last <= enabled;
  end

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (bit_valid) begin bit_q.push_back(bit_data); bit_cyc.push_back(cyc); end
      if (frame_start) begin fs_cnt++; fs_cyc = cyc; end
      if (frame_end) begin fe_cnt++; fe_cyc = cyc; end
      if (error) begin err_cnt++; err_cyc = cyc; end
      if (!en_last && (bit_valid || frame_start || frame_end || error)) dis_pulse++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic lvl, input int n);
    demod_in = lvl;
    repeat (n) @(negedge clock);
  endtask

  // ivs = {tari, rtcal, first, data...}; each interval is high then PW low.
  task automatic send_frame(input int delim, input int ivs[$], input int dis_idx, input int idle_n);
    rise_cyc.delete();
    hold(1'b0, delim);
    for (int k = 0; k < ivs.size(); k++) begin
      rise_cyc.push_back(cyc);
      if (k == dis_idx) begin
        hold(1'b1, 5);
        enabled = 1'b0;
        repeat (15) @(negedge clock);
        enabled = 1'b1;
        hold(1'b1, ivs[k] - PW - 5);
      end else begin
        hold(1'b1, ivs[k] - PW);
      end
      hold(1'b0, PW);
    end
    rise_cyc.push_back(cyc);
    hold(1'b1, idle_n);
  endtask

  task automatic model_frame(input int delim, input int ivs[$]);
    e_bits.delete();
    e_fs = 0; e_fe = 0; e_err = 0;
    if (delim < DELIM_MIN || ivs.size() < 2) return;
    m_tari  = ivs[0];
    m_rtcal = ivs[1];
    if (m_rtcal <= m_tari) begin e_err = 1; return; end
    if (ivs.size() < 3) begin e_err = 1; return; end
    e_fs = 1; e_fe = 1;
    if (ivs[2] > m_rtcal) begin
      m_trcal = ivs[2];
      m_isq   = 1;
    end else begin
      m_isq = 0;
      e_bits.push_back(ivs[2] >= m_rtcal / 2);
    end
    for (int k = 3; k < ivs.size(); k++) e_bits.push_back(ivs[k] >= m_rtcal / 2);
  endtask

  task automatic score_frame(input string tag, input int b_bits, input int b_fs,
                             input int b_fe, input int b_err);
    int nb;
    nb = bit_q.size() - b_bits;
    n_chk++;
    if (nb != e_bits.size()) begin
      n_err++; $display("FAIL %s bit_count: got %0d expected %0d", tag, nb, e_bits.size());
    end
    for (int k = 0; k < nb && k < e_bits.size(); k++) begin
      n_chk++;
      if (bit_q[b_bits+k] !== e_bits[k]) begin
        n_err++; $display("FAIL %s bit[%0d]: got %b expected %b", tag, k, bit_q[b_bits+k], e_bits[k]);
      end
    end
    n_chk++;
    if (fs_cnt - b_fs != int'(e_fs)) begin
      n_err++; $display("FAIL %s frame_start count: got %0d expected %0d", tag, fs_cnt - b_fs, e_fs);
    end
    n_chk++;
    if (fe_cnt - b_fe != int'(e_fe)) begin
      n_err++; $display("FAIL %s frame_end count: got %0d expected %0d", tag, fe_cnt - b_fe, e_fe);
    end
    n_chk++;
    if (err_cnt - b_err != int'(e_err)) begin
      n_err++; $display("FAIL %s error count: got %0d expected %0d", tag, err_cnt - b_err, e_err);
    end
    n_chk++;
    if (tari !== CNT_W'(m_tari) || rtcal !== CNT_W'(m_rtcal) || trcal !== CNT_W'(m_trcal)) begin
      n_err++; $display("FAIL %s latched: got tari=%0d rtcal=%0d trcal=%0d expected %0d %0d %0d",
                        tag, tari, rtcal, trcal, m_tari, m_rtcal, m_trcal);
    end
    n_chk++;
    if (is_query !== m_isq) begin
      n_err++; $display("FAIL %s is_query: got %b expected %b", tag, is_query, m_isq);
    end
    if (e_fs) begin
      n_chk++;
      if (fs_cyc != rise_cyc[3] + LAT) begin
        n_err++; $display("FAIL %s frame_start cycle: got %0d expected %0d", tag, fs_cyc, rise_cyc[3] + LAT);
      end
      if (!m_isq && nb > 0) begin
        n_chk++;
        if (bit_cyc[b_bits] != fs_cyc) begin
          n_err++; $display("FAIL %s first bit cycle: got %0d expected %0d", tag, bit_cyc[b_bits], fs_cyc);
        end
      end
    end
    if (e_fe) begin
      n_chk++;
      if (fe_cyc != rise_cyc[rise_cyc.size()-1] + LAT + TIMEOUT) begin
        n_err++; $display("FAIL %s frame_end cycle: got %0d expected %0d", tag, fe_cyc,
                          rise_cyc[rise_cyc.size()-1] + LAT + TIMEOUT);
      end
    end
    if (e_err && rise_cyc.size() > 2) begin
      n_chk++;
      if (err_cyc != rise_cyc[2] + LAT) begin
        n_err++; $display("FAIL %s error cycle: got %0d expected %0d", tag, err_cyc, rise_cyc[2] + LAT);
      end
    end
  endtask

  task automatic do_frame(input string tag, input int delim, input int ivs[$],
                          input int dis_idx, input int idle_n);
    int b_bits, b_fs, b_fe, b_err;
    b_bits = bit_q.size(); b_fs = fs_cnt; b_fe = fe_cnt; b_err = err_cnt;
    send_frame(delim, ivs, dis_idx, idle_n);
    model_frame(delim, ivs);
    score_frame(tag, b_bits, b_fs, b_fe, b_err);
  endtask

  task automatic test_reset();
    reset = 1'b0; enabled = 1'b1; demod_in = 1'b1;
    repeat (3) @(negedge clock);
    n_chk++;
    if ({bit_data, bit_valid, frame_start, is_query, frame_end, error} !== 6'b0) begin
      n_err++; $display("FAIL reset flags: got %b expected 000000",
                        {bit_data, bit_valid, frame_start, is_query, frame_end, error});
    end
    n_chk++;
    if ({tari, rtcal, trcal} !== '0) begin
      n_err++; $display("FAIL reset measurements: got %0d %0d %0d expected 0 0 0", tari, rtcal, trcal);
    end
    reset = 1'b1;
    hold(1'b1, 6);
  endtask

  task automatic test_query();
    int q[$];
    q = {20, 50, 80, 20, 40};
    do_frame("query", 10, q, -1, TIMEOUT + 20);
  endtask

  task automatic test_data_first();
    int q[$];
    q = {20, 50, 24, 25, 30};
    do_frame("data_first", 10, q, -1, TIMEOUT + 20);
  endtask

  task automatic test_glitch();
    int q[$];
    q.delete();
    do_frame("glitch5", 5, q, -1, 40);
    do_frame("glitch7", 7, q, -1, 40);
    q = {20, 50, 80, 20, 40};
    do_frame("delim8", 8, q, -1, TIMEOUT + 20);
  endtask

  task automatic test_error();
    int q[$];
    q = {30, 30};
    do_frame("rtcal_eq_tari", 10, q, -1, 40);
    q = {30, 31, 40, 15, 14};
    do_frame("rtcal_tari_plus1", 10, q, -1, TIMEOUT + 20);
  endtask

  task automatic test_boundaries();
    int q[$];
    q = {20, 51, 51, 25, 24, 26};
    do_frame("slice_bounds", 9, q, -1, TIMEOUT + 20);
  endtask

  task automatic test_timeout_delim();
    int b_err, b_fs, f0;
    b_err = err_cnt; b_fs = fs_cnt;
    f0 = cyc;
    hold(1'b0, TIMEOUT + 9);
    hold(1'b1, 40);
    n_chk++;
    if (err_cnt - b_err != 1 || fs_cnt != b_fs) begin
      n_err++; $display("FAIL delim_timeout counts: got err=%0d fs=%0d expected err=1 fs=0",
                        err_cnt - b_err, fs_cnt - b_fs);
    end
    n_chk++;
    if (err_cyc != f0 + LAT + TIMEOUT) begin
      n_err++; $display("FAIL delim_timeout cycle: got %0d expected %0d", err_cyc, f0 + LAT + TIMEOUT);
    end
  endtask

  task automatic test_fall_at_timeout();
    int q[$];
    int b_bits, b_fs, b_fe, b_err;
    q = {20, 50, 80, 40, 20};
    b_bits = bit_q.size(); b_fs = fs_cnt; b_fe = fe_cnt; b_err = err_cnt;
    send_frame(10, q, -1, TIMEOUT);
    hold(1'b0, 20);
    hold(1'b1, TIMEOUT + 20);
    model_frame(10, q);
    score_frame("fall_at_timeout", b_bits, b_fs, b_fe, b_err);
  endtask

  task automatic test_disable();
    int q[$];
    int b_dis;
    b_dis = dis_pulse;
    q = {12, 30, 20, 12, 40};
    do_frame("disable", 10, q, 3, TIMEOUT + 20);
    n_chk++;
    if (dis_pulse != b_dis) begin
      n_err++; $display("FAIL disable pulses: got %0d expected 0", dis_pulse - b_dis);
    end
  endtask

  task automatic test_reset_mid_data();
    int q[$];
    int b_fe, b_err;
    q = {20, 50, 24, 30, 40};
    send_frame(10, q, -1, 5);
    n_chk++;
    if (tari !== CNT_W'(20) || rtcal !== CNT_W'(50)) begin
      n_err++; $display("FAIL pre_reset latched: got tari=%0d rtcal=%0d expected 20 50", tari, rtcal);
    end
    b_fe = fe_cnt; b_err = err_cnt;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({bit_data, bit_valid, frame_start, is_query, frame_end, error, tari, rtcal, trcal} !== '0) begin
      n_err++; $display("FAIL mid_reset outputs: got tari=%0d rtcal=%0d trcal=%0d flags=%b expected all 0",
                        tari, rtcal, trcal, {bit_data, bit_valid, frame_start, is_query, frame_end, error});
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    m_tari = 0; m_rtcal = 0; m_trcal = 0; m_isq = 0;
    hold(1'b1, TIMEOUT + 20);
    n_chk++;
    if (fe_cnt != b_fe || err_cnt != b_err) begin
      n_err++; $display("FAIL mid_reset pulses: got fe=%0d err=%0d expected 0 0", fe_cnt - b_fe, err_cnt - b_err);
    end
  endtask

  task automatic test_random();
    int q[$];
    int t, r, n, dl;
    for (int f = 0; f < 8; f++) begin
      q.delete();
      t  = $urandom_range(30, 12);
      dl = $urandom_range(20, 8);
      if ($urandom_range(4, 0) == 0) r = $urandom_range(t, 6);
      else r = $urandom_range(3 * t, t + 1);
      q.push_back(t);
      q.push_back(r);
      if ($urandom_range(1, 0) == 1) q.push_back($urandom_range(3 * r, r + 1));
      else q.push_back($urandom_range(r, 6));
      n = $urandom_range(10, 3);
      for (int k = 0; k < n; k++) q.push_back($urandom_range(2 * r, 6));
      do_frame($sformatf("random%0d", f), dl, q, -1, TIMEOUT + 20);
    end
  endtask

  initial begin
    test_reset();
    test_query();
    test_data_first();
    test_glitch();
    test_error();
    test_boundaries();
    test_timeout_delim();
    test_fall_at_timeout();
    test_disable();
    test_reset_mid_data();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
